// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the load-use hazard unit: forward-select encodings,
// legal load-latency range and scoreboard counter width.
package hazard_unit_pkg;

  // Operand source select driven onto fwd1/fwd2
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned LOAD_LAT_MIN = 1;
  localparam int unsigned LOAD_LAT_MAX = 7;

  // Width of each per-register countdown; must hold LOAD_LAT_MAX
  localparam int unsigned SB_CNT_W = 3;

  // Forwarding priority: EX result beats MEM result; unused operands read the regfile
  function automatic fwd_sel_e fwd_pick(input logic used, input logic ex_hit,
                                        input logic mem_hit);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (used && ex_hit) begin
      sel = FWD_EX;
    end else if (used && mem_hit) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit bundle. master = pipeline side, slave = hazard unit.
interface hazard_unit_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);

  logic              dec_valid;
  logic              dec_use1;
  logic              dec_use2;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic              ex_valid;
  logic              ex_load;
  logic              ex_wb;
  logic [REG_AW-1:0] ex_rdst;
  logic              mem_valid;
  logic              mem_wb;
  logic [REG_AW-1:0] mem_rdst;
  logic              flush;
  logic              stallD;
  logic [1:0]        fwd1;
  logic [1:0]        fwd2;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output dec_valid, dec_use1, dec_use2, dec_rs1, dec_rs2,
    output ex_valid, ex_load, ex_wb, ex_rdst,
    output mem_valid, mem_wb, mem_rdst, flush,
    input  stallD, fwd1, fwd2, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_use1, dec_use2, dec_rs1, dec_rs2,
    input  ex_valid, ex_load, ex_wb, ex_rdst,
    input  mem_valid, mem_wb, mem_rdst, flush,
    output stallD, fwd1, fwd2, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register load countdown scoreboard. A load issue reloads its
// destination count with LOAD_LAT, other nonzero counts tick down by one,
// and flush clears everything on the same edge.
module hazard_scoreboard
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_i,
  input  logic [REG_AW-1:0]   issue_idx_i,
  input  logic                flush_i,
  output logic [SB_CNT_W-1:0] cnt_o [2**REG_AW]
);

  localparam int unsigned NReg = 2 ** REG_AW;

  // Out-of-range latencies are pinned to the legal range
  localparam int unsigned LatClamp = (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX :
                                     (LOAD_LAT < LOAD_LAT_MIN) ? LOAD_LAT_MIN : LOAD_LAT;
  localparam logic [SB_CNT_W-1:0] LatVal = SB_CNT_W'(LatClamp);

  logic [SB_CNT_W-1:0] cnt_q [NReg];
  logic [SB_CNT_W-1:0] cnt_d [NReg];

  // Next count: flush > issue reload > decrement
  always_comb begin
    for (int i = 0; i < NReg; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = '0;
      end else if (issue_i && (issue_idx_i == REG_AW'(i))) begin
        cnt_d[i] = LatVal;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Count registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NReg; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use hazard detection and operand forwarding for an in-order pipeline.
// Build option: define HAZARD_FWD_EN to enable EX/MEM forwarding; without it
// fwd1/fwd2 stay at regfile and any pending producer of a used source stalls.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_unit_if.slave bus
);

  localparam int unsigned NReg = 2 ** REG_AW;

  logic [SB_CNT_W-1:0] cnt [NReg];
  logic                ld_ex;
  logic                ex_wr;
  logic                mem_wr;
  logic                issue;
  logic                hit1;
  logic                hit2;
  logic                stall;
  fwd_sel_e            sel1;
  fwd_sel_e            sel2;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;

  assign ld_ex  = bus.ex_valid & bus.ex_load & bus.ex_wb;
  assign ex_wr  = bus.ex_valid & bus.ex_wb;
  assign mem_wr = bus.mem_valid & bus.mem_wb;
  assign issue  = ld_ex & ~bus.flush;

  hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .LOAD_LAT(LOAD_LAT)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_i    (issue),
    .issue_idx_i(bus.ex_rdst),
    .flush_i    (bus.flush),
    .cnt_o      (cnt)
  );

  // Per-operand hazard detection and forward-source selection
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    sel1 = FWD_RF;
    sel2 = FWD_RF;
`ifdef HAZARD_FWD_EN
    // A count of 1 means the load result is in MEM and can be forwarded
    hit1 = (cnt[bus.dec_rs1] > SB_CNT_W'(1)) | (ld_ex & (bus.ex_rdst == bus.dec_rs1));
    hit2 = (cnt[bus.dec_rs2] > SB_CNT_W'(1)) | (ld_ex & (bus.ex_rdst == bus.dec_rs2));
    sel1 = fwd_pick(bus.dec_use1, ex_wr & ~bus.ex_load & (bus.ex_rdst == bus.dec_rs1),
                    mem_wr & (bus.mem_rdst == bus.dec_rs1));
    sel2 = fwd_pick(bus.dec_use2, ex_wr & ~bus.ex_load & (bus.ex_rdst == bus.dec_rs2),
                    mem_wr & (bus.mem_rdst == bus.dec_rs2));
`else
    // No bypass network: wait until every in-flight producer has retired
    hit1 = (cnt[bus.dec_rs1] != '0) | (ex_wr & (bus.ex_rdst == bus.dec_rs1)) |
           (mem_wr & (bus.mem_rdst == bus.dec_rs1));
    hit2 = (cnt[bus.dec_rs2] != '0) | (ex_wr & (bus.ex_rdst == bus.dec_rs2)) |
           (mem_wr & (bus.mem_rdst == bus.dec_rs2));
`endif
  end

  // rst_n gating keeps outputs quiet while reset is held even if EX shows a load
  assign stall = rst_n & bus.dec_valid & ~bus.flush &
                 ((bus.dec_use1 & hit1) | (bus.dec_use2 & hit2));

  assign bus.stallD = stall;
  assign bus.fwd1   = rst_n ? sel1 : FWD_RF;
  assign bus.fwd2   = rst_n ? sel2 : FWD_RF;

  // Saturating stall counter next state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Two instances share one stimulus stream:
// dut2 (LOAD_LAT=2, CNT_W=16) and dut4 (LOAD_LAT=4, CNT_W=4).
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid, dec_use1, dec_use2;
  logic [2:0] dec_rs1, dec_rs2;
  logic       ex_valid, ex_load, ex_wb;
  logic [2:0] ex_rdst;
  logic       mem_valid, mem_wb;
  logic [2:0] mem_rdst;
  logic       flush;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(3), .CNT_W(16)) bus2 ();
  hazard_unit_if #(.REG_AW(3), .CNT_W(4))  bus4 ();

  assign bus2.dec_valid = dec_valid;
  assign bus2.dec_use1  = dec_use1;
  assign bus2.dec_use2  = dec_use2;
  assign bus2.dec_rs1   = dec_rs1;
  assign bus2.dec_rs2   = dec_rs2;
  assign bus2.ex_valid  = ex_valid;
  assign bus2.ex_load   = ex_load;
  assign bus2.ex_wb     = ex_wb;
  assign bus2.ex_rdst   = ex_rdst;
  assign bus2.mem_valid = mem_valid;
  assign bus2.mem_wb    = mem_wb;
  assign bus2.mem_rdst  = mem_rdst;
  assign bus2.flush     = flush;

  assign bus4.dec_valid = dec_valid;
  assign bus4.dec_use1  = dec_use1;
  assign bus4.dec_use2  = dec_use2;
  assign bus4.dec_rs1   = dec_rs1;
  assign bus4.dec_rs2   = dec_rs2;
  assign bus4.ex_valid  = ex_valid;
  assign bus4.ex_load   = ex_load;
  assign bus4.ex_wb     = ex_wb;
  assign bus4.ex_rdst   = ex_rdst;
  assign bus4.mem_valid = mem_valid;
  assign bus4.mem_wb    = mem_wb;
  assign bus4.mem_rdst  = mem_rdst;
  assign bus4.flush     = flush;

  hazard_unit #(.REG_AW(3), .LOAD_LAT(2), .CNT_W(16)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  hazard_unit #(.REG_AW(3), .LOAD_LAT(4), .CNT_W(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_use1 = 0; dec_use2 = 0; dec_rs1 = 0; dec_rs2 = 0;
    ex_valid  = 0; ex_load  = 0; ex_wb    = 0; ex_rdst = 0;
    mem_valid = 0; mem_wb   = 0; mem_rdst = 0; flush   = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_ld(input logic [2:0] r);
    ex_valid = 1; ex_load = 1; ex_wb = 1; ex_rdst = r;
  endtask

  task automatic dec_rd1(input logic [2:0] r);
    dec_valid = 1; dec_use1 = 1; dec_rs1 = r;
  endtask

  logic [4:0] exp4;
  logic [4:0] exp2;

  initial begin
    // Reset held: outputs quiet even with a live load hazard on the inputs
    rst_n = 0;
    idle();
    ex_ld(3'd3);
    dec_rd1(3'd3);
    mem_valid = 1; mem_wb = 1; mem_rdst = 3'd3;
    #1;
    check_eq("rst_stall", bus2.stallD, 1'b0);
    check_eq("rst_fwd1", bus2.fwd1, 2'b00);
    cyc();
    cyc();
    check_eq("rst_cnt2", bus2.stall_cnt, 32'd0);
    check_eq("rst_cnt4", bus4.stall_cnt, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1;

    // Load r3 in EX with dependent decode
    ex_ld(3'd3);
    dec_rd1(3'd3);
    #1;
    check_eq("ld_ex_stall", bus2.stallD, 1'b1);
    check_eq("ld_ex_fwd1", bus2.fwd1, 2'b00);
    cyc();
    // Load now in MEM, dut2 count=2
    ex_valid = 0; ex_load = 0; ex_wb = 0;
    mem_valid = 1; mem_wb = 1; mem_rdst = 3'd3;
    #1;
    check_eq("stall_cnt_1", bus2.stall_cnt, 32'd1);
    check_eq("cnt2_stall", bus2.stallD, 1'b1);
    cyc();
    // dut2 count=1: forward from MEM when enabled; dut4 count=3
    #1;
    check_eq("cnt1_stall", bus2.stallD, FwdEn ? 1'b0 : 1'b1);
    check_eq("cnt1_fwd1", bus2.fwd1, FwdEn ? 2'b10 : 2'b00);
    check_eq("lat4_cnt3_stall", bus4.stallD, 1'b1);
    cyc();
    flush = 1;
    #1;
    check_eq("flush_stall2", bus2.stallD, 1'b0);
    check_eq("flush_stall4", bus4.stallD, 1'b0);
    cyc();

    // Source matches only through an unused rs2 field
    idle();
    ex_ld(3'd3);
    mem_valid = 1; mem_wb = 1; mem_rdst = 3'd3;
    dec_valid = 1; dec_rs2 = 3'd3;
    #1;
    check_eq("stall_cnt_2", bus2.stall_cnt, FwdEn ? 32'd2 : 32'd3);
    check_eq("unused_stall", bus2.stallD, 1'b0);
    check_eq("unused_fwd2", bus2.fwd2, 2'b00);
    cyc();
    idle();
    flush = 1;
    cyc();

    // ALU write r5 in EX and MEM, both sources r5: EX wins
    idle();
    ex_valid = 1; ex_wb = 1; ex_rdst = 3'd5;
    mem_valid = 1; mem_wb = 1; mem_rdst = 3'd5;
    dec_valid = 1; dec_use1 = 1; dec_use2 = 1; dec_rs1 = 3'd5; dec_rs2 = 3'd5;
    #1;
    check_eq("alu_stall", bus2.stallD, FwdEn ? 1'b0 : 1'b1);
    check_eq("alu_fwd1", bus2.fwd1, FwdEn ? 2'b01 : 2'b00);
    check_eq("alu_fwd2", bus2.fwd2, FwdEn ? 2'b01 : 2'b00);
    cyc();
    // EX no longer valid: rs2 gets MEM, rs1=6 gets regfile
    ex_valid = 0;
    dec_rs1 = 3'd6;
    #1;
    check_eq("mem_fwd1", bus2.fwd1, 2'b00);
    check_eq("mem_fwd2", bus2.fwd2, FwdEn ? 2'b10 : 2'b00);
    check_eq("mem_stall", bus2.stallD, FwdEn ? 1'b0 : 1'b1);
    cyc();

    // No valid decode never stalls, even with a pending load
    idle();
    ex_ld(3'd5);
    dec_use1 = 1; dec_rs1 = 3'd5;
    #1;
    check_eq("nodec_ex_stall", bus2.stallD, 1'b0);
    cyc();
    ex_valid = 0; ex_load = 0; ex_wb = 0;
    #1;
    check_eq("nodec_sb_stall", bus2.stallD, 1'b0);
    dec_valid = 1;
    #1;
    check_eq("sb_stall", bus2.stallD, 1'b1);
    cyc();
    idle();
    flush = 1;
    cyc();

    // Load r2 issued, flushed next cycle
    idle();
    ex_ld(3'd2);
    cyc();
    idle();
    flush = 1;
    dec_rd1(3'd2);
    #1;
    check_eq("flush_force", bus2.stallD, 1'b0);
    cyc();
    flush = 0;
    #1;
    check_eq("flush_clear2", bus2.stallD, 1'b0);
    check_eq("flush_clear4", bus4.stallD, 1'b0);
    cyc();

    // Load coinciding with flush does not issue
    idle();
    ex_ld(3'd4);
    flush = 1;
    cyc();
    idle();
    dec_rd1(3'd4);
    #1;
    check_eq("flush_noissue", bus2.stallD, 1'b0);
    cyc();

    // Back-to-back loads to r1 reload the count
    idle();
    ex_ld(3'd1);
    cyc();
    cyc();
    idle();
    dec_rd1(3'd1);
    // dut4 counts 4,3,2,1,0; dut2 counts 2,1,0,0,0
    exp4 = FwdEn ? 5'b00111 : 5'b01111;
    exp2 = FwdEn ? 5'b00001 : 5'b00011;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("reload4_%0d", k), bus4.stallD, exp4[k]);
      check_eq($sformatf("reload2_%0d", k), bus2.stallD, exp2[k]);
      cyc();
    end

    // 20 stall cycles saturate the 4-bit counter
    idle();
    ex_ld(3'd7);
    dec_rd1(3'd7);
    for (int k = 0; k < 20; k++) begin
      cyc();
    end
    #1;
    check_eq("sat_cnt4", bus4.stall_cnt, 32'd15);
    #1;
    rst_n = 0;
    #1;
    check_eq("async_rst_cnt4", bus4.stall_cnt, 32'd0);
    check_eq("async_rst_cnt2", bus2.stall_cnt, 32'd0);
    check_eq("async_rst_stall", bus4.stallD, 1'b0);
    ex_valid = 0; ex_load = 0; ex_wb = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    check_eq("post_rst_empty2", bus2.stallD, 1'b0);
    check_eq("post_rst_empty4", bus4.stallD, 1'b0);
    // First edge after release issues normally
    dec_valid = 0;
    ex_ld(3'd7);
    cyc();
    idle();
    dec_rd1(3'd7);
    #1;
    check_eq("post_rst_issue2", bus2.stallD, 1'b1);
    check_eq("post_rst_issue4", bus4.stallD, 1'b1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
